// File: rtl/baccarat_pkg.sv
// Shared types, constants and scoring helpers for the baccarat hand controller.
// Optional build macro used by the top: BACCARAT_AUTORESTART_EN.
package baccarat_pkg;

  localparam int CARD_W  = 4;
  localparam int SCORE_W = 4;

  typedef logic [CARD_W-1:0]  card_t;
  typedef logic [SCORE_W-1:0] score_t;

  typedef enum logic [3:0] {
    DEAL_P1,
    DEAL_D1,
    DEAL_P2,
    DEAL_D2,
    CHECK,
    DEAL_P3,
    BANKER,
    DEAL_D3,
    DONE
  } state_t;

  localparam card_t CARD_NONE = 4'd0;
  localparam card_t CARD_MAX  = 4'd13;

  // Ace..9 count face value; 10, J, Q, K and the empty slot count zero.
  function automatic score_t card_value(input card_t c);
    if (c >= 4'd1 && c <= 4'd9) return score_t'(c);
    else                        return '0;
  endfunction

  // Adds two 0..9 values and wraps back into 0..9.
  function automatic score_t add_mod10(input score_t a, input score_t b);
    logic [4:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= 5'd10) s = s - 5'd10;
    return s[SCORE_W-1:0];
  endfunction

endpackage

// File: rtl/baccarat_ctrl_hand_score.sv
// Combinational mod-10 score of a three-card hand; empty slots count zero.
module hand_score (
  input  logic [3:0] card1,
  input  logic [3:0] card2,
  input  logic [3:0] card3,
  output logic [3:0] score
);
  import baccarat_pkg::*;

  // Fold the three card values together, wrapping after each add.
  always_comb begin
    score = add_mod10(add_mod10(card_value(card1), card_value(card2)),
                      card_value(card3));
  end

endmodule

// File: rtl/baccarat_ctrl.sv
// Baccarat hand sequencer: latches dealt cards, applies the natural and
// third-card rules, and flags the winner once the hand is complete.
// Build option: define BACCARAT_AUTORESTART_EN to let step in DONE start a
// fresh hand; without it DONE holds until reset.
//
// state   | meaning
// --------+----------------------------------------------------------
// DEAL_P1 | wait for player first card
// DEAL_D1 | wait for banker first card
// DEAL_P2 | wait for player second card
// DEAL_D2 | wait for banker second card
// CHECK   | one cycle: natural / player-draw / banker-draw decision
// DEAL_P3 | wait for player third card
// BANKER  | one cycle: banker tableau against player third card
// DEAL_D3 | wait for banker third card
// DONE    | hand complete, win flags valid
module baccarat_ctrl #(
  parameter int CARD_W  = 4,
  parameter int SCORE_W = 4
) (
  input  logic               slow_clock,
  input  logic               reset,
  input  logic               step,
  input  logic [CARD_W-1:0]  new_card,
  output logic [CARD_W-1:0]  pcard1,
  output logic [CARD_W-1:0]  pcard2,
  output logic [CARD_W-1:0]  pcard3,
  output logic [CARD_W-1:0]  dcard1,
  output logic [CARD_W-1:0]  dcard2,
  output logic [CARD_W-1:0]  dcard3,
  output logic [SCORE_W-1:0] pscore,
  output logic [SCORE_W-1:0] dscore,
  output logic               player_win,
  output logic               dealer_win,
  output logic               done
);
  import baccarat_pkg::*;

  state_t state;
  logic   card_ok;
  logic   take;
  logic   banker_draw;
  score_t v3;
  score_t dscore_d3;

  hand_score u_player (
    .card1 (pcard1),
    .card2 (pcard2),
    .card3 (pcard3),
    .score (pscore)
  );

  hand_score u_banker (
    .card1 (dcard1),
    .card2 (dcard2),
    .card3 (dcard3),
    .score (dscore)
  );

  // Qualify the offered card and precompute the banker decision inputs.
  always_comb begin
    card_ok   = (new_card != CARD_NONE) && (new_card <= CARD_MAX);
    take      = step && card_ok;
    v3        = card_value(pcard3);
    // dcard3 is still empty in DEAL_D3, so the final banker score is the
    // current score plus the card being loaded.
    dscore_d3 = add_mod10(dscore, card_value(new_card));
    case (dscore)
      4'd0, 4'd1, 4'd2: banker_draw = 1'b1;
      4'd3:             banker_draw = (v3 != 4'd8);
      4'd4:             banker_draw = (v3 >= 4'd2) && (v3 <= 4'd7);
      4'd5:             banker_draw = (v3 >= 4'd4) && (v3 <= 4'd7);
      4'd6:             banker_draw = (v3 >= 4'd6) && (v3 <= 4'd7);
      default:          banker_draw = 1'b0;
    endcase
  end

  // Hand sequencer; card registers and result flags are all registered here.
  always_ff @(posedge slow_clock) begin
    if (reset) begin
      state      <= DEAL_P1;
      pcard1     <= '0;
      pcard2     <= '0;
      pcard3     <= '0;
      dcard1     <= '0;
      dcard2     <= '0;
      dcard3     <= '0;
      player_win <= 1'b0;
      dealer_win <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        DEAL_P1: if (take) begin pcard1 <= new_card; state <= DEAL_D1; end
        DEAL_D1: if (take) begin dcard1 <= new_card; state <= DEAL_P2; end
        DEAL_P2: if (take) begin pcard2 <= new_card; state <= DEAL_D2; end
        DEAL_D2: if (take) begin dcard2 <= new_card; state <= CHECK;   end
        CHECK: begin
          if (pscore >= 4'd8 || dscore >= 4'd8 || (pscore > 4'd5 && dscore > 4'd5)) begin
            state      <= DONE;
            done       <= 1'b1;
            player_win <= (pscore >= dscore);
            dealer_win <= (dscore >= pscore);
          end else if (pscore <= 4'd5) begin
            state <= DEAL_P3;
          end else begin
            state <= DEAL_D3;
          end
        end
        DEAL_P3: if (take) begin pcard3 <= new_card; state <= BANKER; end
        BANKER: begin
          if (banker_draw) begin
            state <= DEAL_D3;
          end else begin
            state      <= DONE;
            done       <= 1'b1;
            player_win <= (pscore >= dscore);
            dealer_win <= (dscore >= pscore);
          end
        end
        DEAL_D3: begin
          if (take) begin
            dcard3     <= new_card;
            state      <= DONE;
            done       <= 1'b1;
            player_win <= (pscore >= dscore_d3);
            dealer_win <= (dscore_d3 >= pscore);
          end
        end
        DONE: begin
`ifdef BACCARAT_AUTORESTART_EN
          if (step) begin
            state      <= DEAL_P1;
            pcard1     <= '0;
            pcard2     <= '0;
            pcard3     <= '0;
            dcard1     <= '0;
            dcard2     <= '0;
            dcard3     <= '0;
            player_win <= 1'b0;
            dealer_win <= 1'b0;
            done       <= 1'b0;
          end
`endif
        end
        default: state <= DEAL_P1;
      endcase
    end
  end

endmodule

// File: tb/tb_baccarat_ctrl.sv
// Directed bench for baccarat_ctrl; expected output vectors are hand-computed.
// Vector layout: {pcard1,pcard2,pcard3,dcard1,dcard2,dcard3,pscore,dscore,pwin,dwin,done}
module tb_baccarat_ctrl;

  logic       slow_clock = 1'b0;
  logic       reset = 1'b0;
  logic       step = 1'b0;
  logic [3:0] new_card = 4'd0;
  logic [3:0] pcard1, pcard2, pcard3, dcard1, dcard2, dcard3;
  logic [3:0] pscore, dscore;
  logic       player_win, dealer_win, done;
  logic [34:0] obs;
  logic [34:0] exp_v;
  int pass_cnt = 0;
  int total_cnt = 0;

  baccarat_ctrl #(.CARD_W(4), .SCORE_W(4)) dut (
    .slow_clock (slow_clock),
    .reset      (reset),
    .step       (step),
    .new_card   (new_card),
    .pcard1     (pcard1),
    .pcard2     (pcard2),
    .pcard3     (pcard3),
    .dcard1     (dcard1),
    .dcard2     (dcard2),
    .dcard3     (dcard3),
    .pscore     (pscore),
    .dscore     (dscore),
    .player_win (player_win),
    .dealer_win (dealer_win),
    .done       (done)
  );

  always #5 slow_clock = ~slow_clock;

  assign obs = {pcard1, pcard2, pcard3, dcard1, dcard2, dcard3,
                pscore, dscore, player_win, dealer_win, done};

  task automatic tick();
    @(posedge slow_clock);
    #1;
  endtask

  task automatic deal(input logic [3:0] c);
    step = 1'b1;
    new_card = c;
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step = 1'b0;
    new_card = 4'd0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step = 1'b1;
    new_card = 4'd5;
    tick();
    reset = 1'b0;
    step = 1'b0;
    exp_v = '0;
    total_cnt++;
    if (obs !== exp_v) $display("FAIL reset_state got=%h exp=%h", obs, exp_v);
    else pass_cnt++;
  endtask

  task automatic test_natural();
    do_reset();
    deal(4'd8); deal(4'd2); deal(4'd1); deal(4'd3);
    exp_v = {4'd8, 4'd1, 4'd0, 4'd2, 4'd3, 4'd0, 4'd9, 4'd5, 3'b000};
    total_cnt++;
    if (obs !== exp_v) $display("FAIL natural_check got=%h exp=%h", obs, exp_v);
    else pass_cnt++;
    step = 1'b0;
    tick();
    exp_v = {4'd8, 4'd1, 4'd0, 4'd2, 4'd3, 4'd0, 4'd9, 4'd5, 3'b101};
    total_cnt++;
    if (obs !== exp_v) $display("FAIL natural_done got=%h exp=%h", obs, exp_v);
    else pass_cnt++;
  endtask

  task automatic test_player_draw();
    do_reset();
    deal(4'd2); deal(4'd5); deal(4'd3); deal(4'd13);
    new_card = 4'd8;
    tick();
    exp_v = {4'd2, 4'd3, 4'd0, 4'd5, 4'd13, 4'd0, 4'd5, 4'd5, 3'b000};
    total_cnt++;
    if (obs !== exp_v) $display("FAIL pdraw_check_ignores_step got=%h exp=%h", obs, exp_v);
    else pass_cnt++;
    tick();
    exp_v = {4'd2, 4'd3, 4'd8, 4'd5, 4'd13, 4'd0, 4'd3, 4'd5, 3'b000};
    total_cnt++;
    if (obs !== exp_v) $display("FAIL pdraw_p3 got=%h exp=%h", obs, exp_v);
    else pass_cnt++;
    tick();
    step = 1'b0;
    exp_v = {4'd2, 4'd3, 4'd8, 4'd5, 4'd13, 4'd0, 4'd3, 4'd5, 3'b011};
    total_cnt++;
    if (obs !== exp_v) $display("FAIL pdraw_banker_stands got=%h exp=%h", obs, exp_v);
    else pass_cnt++;
  endtask

  task automatic test_banker_draw();
    do_reset();
    deal(4'd4); deal(4'd2); deal(4'd3); deal(4'd1);
    step = 1'b0;
    tick();
    exp_v = {4'd4, 4'd3, 4'd0, 4'd2, 4'd1, 4'd0, 4'd7, 4'd3, 3'b000};
    total_cnt++;
    if (obs !== exp_v) $display("FAIL bdraw_wait_d3 got=%h exp=%h", obs, exp_v);
    else pass_cnt++;
    deal(4'd4);
    step = 1'b0;
    exp_v = {4'd4, 4'd3, 4'd0, 4'd2, 4'd1, 4'd4, 4'd7, 4'd7, 3'b111};
    total_cnt++;
    if (obs !== exp_v) $display("FAIL bdraw_tie got=%h exp=%h", obs, exp_v);
    else pass_cnt++;
  endtask

  task automatic test_banker_six();
    do_reset();
    deal(4'd1); deal(4'd3); deal(4'd2); deal(4'd3);
    step = 1'b0;
    tick();
    deal(4'd6);
    step = 1'b0;
    exp_v = {4'd1, 4'd2, 4'd6, 4'd3, 4'd3, 4'd0, 4'd9, 4'd6, 3'b000};
    total_cnt++;
    if (obs !== exp_v) $display("FAIL b6_p3 got=%h exp=%h", obs, exp_v);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (obs !== exp_v) $display("FAIL b6_banker_draws got=%h exp=%h", obs, exp_v);
    else pass_cnt++;
    deal(4'd2);
    step = 1'b0;
    exp_v = {4'd1, 4'd2, 4'd6, 4'd3, 4'd3, 4'd2, 4'd9, 4'd8, 3'b101};
    total_cnt++;
    if (obs !== exp_v) $display("FAIL b6_done got=%h exp=%h", obs, exp_v);
    else pass_cnt++;
  endtask

  task automatic test_face_cards();
    do_reset();
    deal(4'd9); deal(4'd12); deal(4'd9); deal(4'd11);
    step = 1'b0;
    tick();
    exp_v = {4'd9, 4'd9, 4'd0, 4'd12, 4'd11, 4'd0, 4'd8, 4'd0, 3'b101};
    total_cnt++;
    if (obs !== exp_v) $display("FAIL face_natural got=%h exp=%h", obs, exp_v);
    else pass_cnt++;
    do_reset();
    deal(4'd1); deal(4'd4); deal(4'd1); deal(4'd4);
    step = 1'b0;
    tick();
    exp_v = {4'd1, 4'd1, 4'd0, 4'd4, 4'd4, 4'd0, 4'd2, 4'd8, 3'b011};
    total_cnt++;
    if (obs !== exp_v) $display("FAIL dealer_natural got=%h exp=%h", obs, exp_v);
    else pass_cnt++;
  endtask

  task automatic test_stall();
    do_reset();
    deal(4'd1); deal(4'd1);
    exp_v = {4'd1, 4'd0, 4'd0, 4'd1, 4'd0, 4'd0, 4'd1, 4'd1, 3'b000};
    deal(4'd0);
    total_cnt++;
    if (obs !== exp_v) $display("FAIL stall_card0 got=%h exp=%h", obs, exp_v);
    else pass_cnt++;
    deal(4'd15);
    total_cnt++;
    if (obs !== exp_v) $display("FAIL stall_card15 got=%h exp=%h", obs, exp_v);
    else pass_cnt++;
    deal(4'd14);
    total_cnt++;
    if (obs !== exp_v) $display("FAIL stall_card14 got=%h exp=%h", obs, exp_v);
    else pass_cnt++;
    step = 1'b0;
    new_card = 4'd5;
    tick();
    total_cnt++;
    if (obs !== exp_v) $display("FAIL stall_step_low got=%h exp=%h", obs, exp_v);
    else pass_cnt++;
    deal(4'd5);
    exp_v = {4'd1, 4'd5, 4'd0, 4'd1, 4'd0, 4'd0, 4'd6, 4'd1, 3'b000};
    total_cnt++;
    if (obs !== exp_v) $display("FAIL stall_load_p2 got=%h exp=%h", obs, exp_v);
    else pass_cnt++;
    deal(4'd6);
    step = 1'b0;
    exp_v = {4'd1, 4'd5, 4'd0, 4'd1, 4'd6, 4'd0, 4'd6, 4'd7, 3'b000};
    total_cnt++;
    if (obs !== exp_v) $display("FAIL stall_then_d2 got=%h exp=%h", obs, exp_v);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    deal(4'd9); deal(4'd9); deal(4'd9);
    exp_v = {4'd9, 4'd9, 4'd0, 4'd9, 4'd0, 4'd0, 4'd8, 4'd9, 3'b000};
    total_cnt++;
    if (obs !== exp_v) $display("FAIL mid_three_dealt got=%h exp=%h", obs, exp_v);
    else pass_cnt++;
    reset = 1'b1;
    new_card = 4'd9;
    tick();
    reset = 1'b0;
    exp_v = '0;
    total_cnt++;
    if (obs !== exp_v) $display("FAIL mid_reset_clear got=%h exp=%h", obs, exp_v);
    else pass_cnt++;
    deal(4'd7);
    step = 1'b0;
    exp_v = {4'd7, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd7, 4'd0, 3'b000};
    total_cnt++;
    if (obs !== exp_v) $display("FAIL mid_back_to_p1 got=%h exp=%h", obs, exp_v);
    else pass_cnt++;
  endtask

  task automatic test_done_step();
    do_reset();
    deal(4'd8); deal(4'd2); deal(4'd1); deal(4'd3);
    step = 1'b0;
    tick();
    exp_v = {4'd8, 4'd1, 4'd0, 4'd2, 4'd3, 4'd0, 4'd9, 4'd5, 3'b101};
    total_cnt++;
    if (obs !== exp_v) $display("FAIL done_before_step got=%h exp=%h", obs, exp_v);
    else pass_cnt++;
    deal(4'd7);
`ifdef BACCARAT_AUTORESTART_EN
    exp_v = '0;
    total_cnt++;
    if (obs !== exp_v) $display("FAIL restart_clear got=%h exp=%h", obs, exp_v);
    else pass_cnt++;
    deal(4'd7);
    step = 1'b0;
    exp_v = {4'd7, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd7, 4'd0, 3'b000};
    total_cnt++;
    if (obs !== exp_v) $display("FAIL restart_p1 got=%h exp=%h", obs, exp_v);
    else pass_cnt++;
`else
    total_cnt++;
    if (obs !== exp_v) $display("FAIL done_holds got=%h exp=%h", obs, exp_v);
    else pass_cnt++;
    deal(4'd7);
    step = 1'b0;
    total_cnt++;
    if (obs !== exp_v) $display("FAIL done_holds2 got=%h exp=%h", obs, exp_v);
    else pass_cnt++;
`endif
  endtask

  initial begin
    test_reset();
    test_natural();
    test_player_draw();
    test_banker_draw();
    test_banker_six();
    test_face_cards();
    test_stall();
    test_reset_mid();
    test_done_step();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/baccarat_ctrl.md
Name: baccarat_ctrl

Overview:
Sequencing controller for one hand of baccarat. It latches cards from the dealer source into six card registers, which drive the six card-to-7-segment displays. It scores both hands and applies the natural, player third-card and banker third-card rules. It flags the winner when the hand completes.

Parameters:
CARD_W, 4, width of a card value (1=A..13=K; 0 means no card).
SCORE_W, 4, width of a hand score (0..9).

Ports:
slow_clock  in  1  single system clock; all state changes on the rising edge.
reset  in  1  synchronous, active-high; clears all state on the next rising edge.
step  in  1  advance request, sampled each rising edge; deal states consume one card per edge while high.
new_card  in  CARD_W  card offered by the dealer source; valid 1..13.
pcard1, pcard2, pcard3  out  CARD_W  player cards held (0 = not dealt, displays blank).
dcard1, dcard2, dcard3  out  CARD_W  banker cards held.
pscore, dscore  out  SCORE_W  current hand scores.
player_win, dealer_win  out  1  result; both high = tie.
done  out  1  hand complete; results valid.

Behaviour:
- Reset: all card registers = 0, pscore = dscore = 0, player_win = dealer_win = done = 0, state = DEAL_P1. Reset overrides step. Reset mid-hand discards all dealt cards.
- Card value: 1..9 score face value; 10..13 score 0; 0 scores 0.
- Hand score = (sum of the three card values) mod 10. It is combinational from the card registers, so it updates in the same cycle a card register changes.
- States: DEAL_P1 -> DEAL_D1 -> DEAL_P2 -> DEAL_D2 -> CHECK -> {DEAL_P3 -> BANKER -> DEAL_D3} -> DONE.
- Deal states (DEAL_P1/D1/P2/D2/P3/D3) advance only when step=1 and new_card is 1..13. On that edge new_card loads into the matching register.
- When step=1 with new_card = 0, 14 or 15: no load, state holds.
- When step=0: state holds.
- The card is visible on the output one edge after the step edge.
- CHECK takes one cycle and ignores step. Branches, in priority order:
  - pscore >= 8 or dscore >= 8 (natural) -> DONE.
  - pscore <= 5 -> DEAL_P3.
  - Player stands (6/7) and dscore <= 5 -> DEAL_D3.
  - Otherwise -> DONE.
- BANKER takes one cycle and ignores step. Let v = score value of pcard3. The banker draws (-> DEAL_D3) when any of these holds, otherwise -> DONE:
  - dscore <= 2;
  - dscore == 3 and v != 8;
  - dscore == 4 and v in 2..7;
  - dscore == 5 and v in 4..7;
  - dscore == 6 and v in 6..7.
  dscore == 7 never draws.
- DONE:
  - done = 1.
  - player_win = (pscore > dscore) or tie; dealer_win = (dscore > pscore) or tie.
  - All outputs hold.
  - step is ignored unless the optional feature is enabled.
- Win flags and done are 0 in every state other than DONE.
- Step held high continuously deals one card per edge. CHECK and BANKER still each take one cycle.

Optional Feature:
BACCARAT_AUTORESTART_EN.
- Defined: in DONE, step=1 clears all card registers and the win flags and returns to DEAL_P1 on that edge. No card is consumed on that edge.
- Undefined: DONE is terminal until reset.

Decomposition:
- Package baccarat_pkg holds:
  - state enum typedef state_t (DEAL_P1, DEAL_D1, DEAL_P2, DEAL_D2, CHECK, DEAL_P3, BANKER, DEAL_D3, DONE);
  - card typedef card_t (CARD_W bits);
  - constants CARD_NONE = 0, CARD_MAX = 13;
  - function card_value(card_t) returning 0..9.
- One combinational sub-module, hand_score, takes three cards and returns the mod-10 score. It is instantiated twice, once for the player hand and once for the banker hand.

Test Plan:
- Natural: deal P1=8, D1=2, P2=1, D2=3 with step -> pscore=9, dscore=5, CHECK -> DONE, pcard3=dcard3=0, player_win=1, dealer_win=0, done=1.
- Player draws, banker stands: deal 2,5,3,K (pscore=5, dscore=5), then P3=8 (v=8) -> pscore=3, BANKER with dscore=5, v=8 -> no draw; DONE, dealer_win=1.
- Player stands, banker draws: deal 4,2,3,1 (pscore=7, dscore=3) -> DEAL_D3; D3=4 -> dscore=7; tie, both wins=1.
- Invalid card / stall: in DEAL_P2, step=1 with new_card=0 then 15 -> pcard2 stays 0 and state holds; step=0 with new_card=5 -> no load; step=1 with new_card=5 -> pcard2=5.
- Reset mid-hand: after three cards dealt, reset=1 with step=1 -> next edge all cards 0, scores 0, done=0, state DEAL_P1.
- BACCARAT_AUTORESTART_EN: in DONE, step=1 -> all cards 0, win flags 0, next step with new_card=7 loads pcard1=7. With the macro undefined, the same stimulus leaves all outputs unchanged.
